// File: rtl/udp_pkg.sv
// udp_pkg: shared state encodings and bus constants for the UDP reply arbiter
package udp_pkg;
    localparam int         UDP_ADDR_W = 6;
    localparam logic [3:0] FIFO_FULL  = 4'hf;
    typedef enum logic [5:0] {
        SCAN   = 6'b000001,
        SETTLE = 6'b000010,
        SOF    = 6'b000100,
        LOAD   = 6'b001000,
        DRAIN  = 6'b010000,
        FLUSH  = 6'b100000
    } arb_state_e;
endpackage

// File: rtl/udp_arb_ptr.sv
// udp_arb_ptr: source channel pointer, round-robin or restart-at-zero after each frame
module udp_arb_ptr
    import udp_pkg::*;
#(
    parameter int NUM_CH    = 21,
    parameter int PRIO_MODE = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  skip_i,
    input  logic                  done_i,
    output logic [UDP_ADDR_W-1:0] ptr_o
);
    logic [UDP_ADDR_W-1:0] ptr_q, ptr_d, step;
    // empty channels always step on; finished frames step (RR) or restart at 0 (PRIO)
    always_comb begin
        step  = (ptr_q >= UDP_ADDR_W'(NUM_CH - 1)) ? '0 : ptr_q + UDP_ADDR_W'(1);
        ptr_d = skip_i ? step : done_i ? ((PRIO_MODE != 0) ? '0 : step) : ptr_q;
    end
    // pointer register
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) ptr_q <= '0;
        else         ptr_q <= ptr_d;
    assign ptr_o = ptr_q;
endmodule

// File: rtl/udp_reply_arb.sv
// udp_reply_arb: polls reply FIFOs and copies whole frames to the switch TX FIFO; UDP_ARB_STATS_EN adds frame/error counters
module udp_reply_arb
    import udp_pkg::*;
#(
    parameter int NUM_CH      = 21,
    parameter int DATA_W      = 8,
    parameter int SETTLE_CYC  = 4,
    parameter int GAP_CYC     = 5,
    parameter int MAX_LEN     = 1500,
    parameter int TIMEOUT_CYC = 1023,
    parameter int PRIO_MODE   = 0
) (
    input  logic                  udp_sw_tx_clk,
    input  logic                  reset_n,
    output logic [UDP_ADDR_W-1:0] src_fifo_addr,
    input  logic                  src_sof_n,
    input  logic                  src_eof_n,
    input  logic [DATA_W-1:0]     src_data,
    input  logic                  src_src_rdy_n,
    output logic                  src_dst_rdy_n,
    input  logic [3:0]            fifo_status,
    output logic                  wr_enable,
    output logic [DATA_W-1:0]     wr_data,
    output logic                  wr_data_valid,
    output logic                  wr_good_frame,
    output logic                  wr_bad_frame
`ifdef UDP_ARB_STATS_EN
    ,
    output logic [15:0]           frame_cnt,
    output logic [15:0]           err_cnt
`endif
);
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYC > 1 ? SETTLE_CYC - 1 : 0);
    localparam logic [15:0] GAP_LAST    = 16'(GAP_CYC > 1 ? GAP_CYC - 1 : 0);
    localparam logic [15:0] TO_LAST     = 16'(TIMEOUT_CYC > 1 ? TIMEOUT_CYC - 1 : 0);
    localparam logic [15:0] LEN_MAX     = 16'(MAX_LEN);
    arb_state_e        state_q, state_d;
    logic [15:0]       cyc_q, cyc_d, beat_q, beat_d, idle_q, idle_d, beat_inc;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d, good_q, good_d, bad_q, bad_d;
    logic              xfer, skip, done;
    assign src_dst_rdy_n = !(state_q == SOF || state_q == LOAD || state_q == DRAIN);
    assign wr_enable     = !(state_q == SCAN || state_q == SETTLE);
    assign xfer          = !src_src_rdy_n && !src_dst_rdy_n;
    assign beat_inc      = (beat_q == 16'hffff) ? beat_q : beat_q + 16'd1;
    assign wr_data       = data_q;
    assign wr_data_valid = valid_q;
    assign wr_good_frame = good_q;
    assign wr_bad_frame  = bad_q;
    udp_arb_ptr #(.NUM_CH(NUM_CH), .PRIO_MODE(PRIO_MODE)) u_ptr (
        .clk_i  (udp_sw_tx_clk),
        .rst_ni (reset_n),
        .skip_i (skip),
        .done_i (done),
        .ptr_o  (src_fifo_addr)
    );
    // frame FSM: settle, copy, truncate/abort, then hold wr_enable through the gap
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        beat_d  = beat_q;
        idle_d  = idle_q;
        data_d  = data_q;
        valid_d = 1'b0;
        good_d  = 1'b0;
        bad_d   = 1'b0;
        skip    = 1'b0;
        done    = 1'b0;
        case (state_q)
            SCAN: begin
                cyc_d   = '0;
                beat_d  = '0;
                idle_d  = '0;
                state_d = (fifo_status == FIFO_FULL) ? SCAN : SETTLE;
            end
            SETTLE: begin
                cyc_d = (cyc_q >= SETTLE_LAST) ? '0 : cyc_q + 16'd1;
                if (cyc_q >= SETTLE_LAST) begin
                    skip    = src_src_rdy_n || src_sof_n;
                    state_d = skip ? SCAN : SOF;
                end
            end
            SOF, LOAD: begin
                if (xfer) begin
                    data_d  = src_data;
                    valid_d = 1'b1;
                    beat_d  = beat_inc;
                    idle_d  = '0;
                    good_d  = !src_eof_n;
                    bad_d   = src_eof_n && beat_inc >= LEN_MAX;
                    state_d = good_d ? FLUSH : bad_d ? DRAIN : LOAD;
                end else if (state_q == LOAD) begin
                    idle_d  = idle_q + 16'd1;
                    bad_d   = idle_q >= TO_LAST;
                    state_d = bad_d ? FLUSH : LOAD;
                end
            end
            DRAIN: state_d = (xfer && !src_eof_n) ? FLUSH : DRAIN;
            FLUSH: begin
                done    = cyc_q >= GAP_LAST;
                cyc_d   = done ? '0 : cyc_q + 16'd1;
                state_d = done ? SCAN : FLUSH;
            end
            default: state_d = SCAN;
        endcase
    end
    // state, counters and registered write-side outputs
    always_ff @(posedge udp_sw_tx_clk or negedge reset_n)
        if (!reset_n) begin
            state_q <= SCAN;
            cyc_q   <= '0;
            beat_q  <= '0;
            idle_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            good_q  <= 1'b0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            beat_q  <= beat_d;
            idle_q  <= idle_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            good_q  <= good_d;
            bad_q   <= bad_d;
        end
`ifdef UDP_ARB_STATS_EN
    // wrapping counts of committed and discarded frames
    always_ff @(posedge udp_sw_tx_clk or negedge reset_n)
        if (!reset_n) begin
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            frame_cnt <= frame_cnt + 16'(good_d);
            err_cnt   <= err_cnt + 16'(bad_d);
        end
`endif
endmodule
